// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Multiplexed N-digit 7-segment driver with tear-free frame updates.
// Revision: 1.0
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   din,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      C_DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W:0]        C_BLANK    = (CNT_W+1)'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_DIG_OFF  =
      (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_din_q, act_din_d, pend_din_q, pend_din_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    w_boundary;
  logic                    w_dig_on;
  logic                    w_zero_run;
  logic [3:0]              w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lz;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign w_digit[i] = act_din_q[4*i +: 4];
  end

  // A digit is a leading zero when it and every more-significant digit are 0.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (w_digit[i] == 4'd0);
      w_lz[i]    = (i != 0) && w_zero_run;
    end
  end

  assign w_boundary = (idx_q == C_IDX_LAST) && (div_cnt_q == C_DIV_LAST);
  assign w_dig_on   = ({1'b0, div_cnt_q} >= C_BLANK);

  always_comb begin
    div_cnt_d    = div_cnt_q + 1'b1;
    idx_d        = idx_q;
    act_din_d    = act_din_q;
    act_dp_d     = act_dp_q;
    pend_din_d   = pend_din_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    frame_done_d = w_boundary;

    if (div_cnt_q == C_DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Active buffer only moves at the frame boundary; a load landing exactly
    // there bypasses pending so the newest value wins.
    if (w_boundary) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_din_d = din;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_din_d = pend_din_q;
        act_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_din_d = din;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    dig_en_d = C_DIG_OFF;
    if (w_dig_on) begin
      dig_en_d = C_DIG_OFF ^ (NUM_DIGITS'(1) << idx_q);
      seg_d    = (blank_lz && w_lz[idx_q]) ? 7'h7F : f_decode(w_digit[idx_q]);
      dp_d     = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      act_din_q    <= '0;
      act_dp_q     <= '0;
      pend_din_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      dig_en_q     <= C_DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      act_din_q    <= act_din_d;
      act_dp_q     <= act_dp_d;
      pend_din_q   <= pend_din_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Randomized and directed bench for seg7_scan_driver with a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic [12:0] obs;
  logic [12:0] exp_vec;

  int n_checks = 0;
  int n_errors = 0;

  // Model: time since reset, plus displayed and pending frames as digit arrays.
  int m_t;
  bit m_pv;
  int m_act [N];
  int m_pend [N];
  bit m_dp [N];
  bit m_pdp [N];

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BL),
    .DIG_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .dig_en    (dig_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {seg, dp, dig_en, frame_done};

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: ref_seg = 7'b1000000;
      1: ref_seg = 7'b1111001;
      2: ref_seg = 7'b0100100;
      3: ref_seg = 7'b0110000;
      4: ref_seg = 7'b0011001;
      5: ref_seg = 7'b0010010;
      6: ref_seg = 7'b0000010;
      7: ref_seg = 7'b1111000;
      8: ref_seg = 7'b0000000;
      9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  function automatic int en_to_idx(input logic [3:0] en);
    case (en)
      4'b1110: en_to_idx = 0;
      4'b1101: en_to_idx = 1;
      4'b1011: en_to_idx = 2;
      4'b0111: en_to_idx = 3;
      default: en_to_idx = -1;
    endcase
  endfunction

  task automatic model_reset();
    m_t  = 0;
    m_pv = 1'b0;
    for (int j = 0; j < N; j++) begin
      m_act[j] = 0; m_pend[j] = 0; m_dp[j] = 1'b0; m_pdp[j] = 1'b0;
    end
    exp_vec = {7'h7F, 1'b1, 4'hF, 1'b0};
  endtask

  // One clock: predict the outputs for the current scan position, then apply buffering.
  task automatic step();
    int pos, idx, dv;
    bit zero_above;
    logic [6:0] es;
    logic ed;
    logic [3:0] eg;
    @(posedge clk);
    pos = m_t % FRAME;
    idx = pos / SD;
    dv  = pos % SD;
    es = 7'h7F; ed = 1'b1; eg = 4'hF;
    if (dv >= BL) begin
      eg = ~(4'(1) << idx);
      zero_above = 1'b1;
      for (int j = idx; j < N; j++) if (m_act[j] != 0) zero_above = 1'b0;
      es = (blank_lz && idx > 0 && zero_above) ? 7'h7F : ref_seg(m_act[idx]);
      ed = ~m_dp[idx];
    end
    exp_vec = {es, ed, eg, (pos == FRAME - 1)};
    if (pos == FRAME - 1) begin
      if (load) begin
        for (int j = 0; j < N; j++) begin m_act[j] = int'(din[4*j +: 4]); m_dp[j] = dp_in[j]; end
      end else if (m_pv) begin
        for (int j = 0; j < N; j++) begin m_act[j] = m_pend[j]; m_dp[j] = m_pdp[j]; end
      end
      m_pv = 1'b0;
    end else if (load) begin
      for (int j = 0; j < N; j++) begin m_pend[j] = int'(din[4*j +: 4]); m_pdp[j] = dp_in[j]; end
      m_pv = 1'b1;
    end
    m_t++;
    @(negedge clk);
  endtask

  task automatic align_frame(input string name);
    for (int k = 0; k < FRAME && (m_t % FRAME) != 0; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL %s_align: got %h expected %h", name, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 13'b1111111_1_1111_0) begin
      n_errors++;
      $display("FAIL reset_values: got %h expected %h", obs, 13'b1111111_1_1111_0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] pat [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL idle_model k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      n_checks++;
      if (dig_en !== pat[k % 16] || frame_done !== ((k % 16) == 15) ||
          (dig_en !== 4'hF && seg !== 7'b1000000)) begin
        n_errors++;
        $display("FAIL idle_pattern k=%0d: got en=%b fd=%b seg=%b expected en=%b", k, dig_en,
                 frame_done, seg, pat[k % 16]);
      end
    end
  endtask

  task automatic test_load_midframe();
    align_frame("midframe");
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k == 4) begin load = 1'b1; din = 16'h1234; dp_in = 4'h0; end
      if (k == 5) load = 1'b0;
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL midframe_model k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (k < FRAME && dig_en !== 4'hF) begin
        n_checks++;
        if (seg !== 7'b1000000) begin
          n_errors++;
          $display("FAIL midframe_torn k=%0d: got %b expected %b", k, seg, 7'b1000000);
        end
      end
      if (k >= FRAME && (dig_en === 4'hE || dig_en === 4'h7)) begin
        n_checks++;
        if (seg !== ((dig_en === 4'hE) ? 7'b0011001 : 7'b1111001)) begin
          n_errors++;
          $display("FAIL midframe_new en=%b: got %b", dig_en, seg);
        end
      end
    end
  endtask

  task automatic run_frame_pair(input string name, input logic [15:0] d, input logic [3:0] p,
                                input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3,
                                input logic [3:0] edp);
    logic [6:0] exp_seg [4];
    int id;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    align_frame(name);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k == 0) begin load = 1'b1; din = d; dp_in = p; end
      if (k == 1) load = 1'b0;
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL %s_model k=%0d: got %h expected %h", name, k, obs, exp_vec);
      end
      id = en_to_idx(dig_en);
      if (k >= FRAME && id >= 0) begin
        n_checks++;
        if (seg !== exp_seg[id] || dp !== edp[id]) begin
          n_errors++;
          $display("FAIL %s_digit%0d: got seg=%b dp=%b expected seg=%b dp=%b", name, id, seg, dp,
                   exp_seg[id], edp[id]);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    blank_lz = 1'b1;
    run_frame_pair("lz0070", 16'h0070, 4'h0, 7'b1000000, 7'b1111000, 7'h7F, 7'h7F, 4'hF);
    run_frame_pair("lz0000", 16'h0000, 4'h0, 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'hF);
  endtask

  task automatic test_invalid_dp();
    blank_lz = 1'b0;
    run_frame_pair("dp00af", 16'h00AF, 4'b0010, 7'h7F, 7'h7F, 7'b1000000, 7'b1000000, 4'b1101);
  endtask

  task automatic test_boundary_load();
    align_frame("boundary");
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k == 0)  begin load = 1'b1; din = 16'h1111; dp_in = 4'h0; end
      if (k == 1)  load = 1'b0;
      if (k == 15) begin load = 1'b1; din = 16'h9999; end
      if (k == 16) load = 1'b0;
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL boundary_model k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (k >= FRAME && dig_en !== 4'hF) begin
        n_checks++;
        if (seg !== 7'b0010000) begin
          n_errors++;
          $display("FAIL boundary_9999 k=%0d: got %b expected %b", k, seg, 7'b0010000);
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    for (int k = 0; k < FRAME && (m_t % FRAME) != 9; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL rstmid_align: got %h expected %h", obs, exp_vec);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'b1111111_1_1111_0) begin
      n_errors++;
      $display("FAIL rstmid_immediate: got %h expected %h", obs, 13'b1111111_1_1111_0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL rstmid_model k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (k == 1) begin
        n_checks++;
        if (dig_en !== 4'hE || seg !== 7'b1000000) begin
          n_errors++;
          $display("FAIL rstmid_first_digit: got en=%b seg=%b expected en=1110 seg=1000000",
                   dig_en, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      load = ($urandom_range(0, 5) == 0);
      if (load) begin
        for (int j = 0; j < N; j++)
          din[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
      step();
      n_checks++;
      if (obs !== exp_vec) begin
        n_errors++;
        $display("FAIL random k=%0d: got %h expected %h", k, obs, exp_vec);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_lz_blank();
    test_boundary_load();
    test_invalid_dp();
    test_reset_midscan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
